sha256_host_ctrl: RTL and testbench

Host-side initiator for the SHA-256 core's word-serial cmd/text port; it plays the role the UVM driver plays on the bench. Accepts 512-bit message blocks as 16 x 32-bit words on a valid/ready stream and writes them into the core. It waits for each compression to finish. After the last block of a message it reads back the eight hash words and presents the 256-bit digest with a valid/ready handshake.

---
 rtl/sha256_pkg.sv | 30 +++
 rtl/sha256_host_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_sha256_host_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 host-side controller.
//   ctrl_state_t : controller FSM states
//   CMD_WRITE    : op code that writes one message word into the core
//   CMD_READ     : op code that reads back one hash word from the core
//   BUSY_BIT     : position of the busy flag inside the core status word
//   HASH_WORDS   : number of 32-bit words in a digest
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_RISE,
    WAIT_FALL,
    READ,
    CAPT,
    OUT,
    ERR
  } ctrl_state_t;

  localparam logic [1:0]  CMD_WRITE  = 2'b10;
  localparam logic [1:0]  CMD_READ   = 2'b01;
  localparam int unsigned BUSY_BIT   = 3;
  localparam int unsigned HASH_WORDS = 8;

  // Command word as the core expects it: {first, op}.
  function automatic logic [2:0] core_cmd(input logic first, input logic [1:0] op);
    return {first, op};
  endfunction

endpackage

// File: rtl/sha256_host_ctrl.sv
// Host-side initiator for the SHA-256 core's word-serial cmd/text port.
// Accepts 512-bit message blocks as WORDS_PER_BLK 32-bit words on a
// valid/ready stream, writes them into the core, waits for each compression
// to finish and, after the last block of a message, reads the eight hash
// words back and offers the digest on a valid/ready output.
//
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   s_valid/s_ready      : upstream word handshake
//   s_data               : message word (W0 first)
//   s_first/s_last       : block position in message, sampled with word 0
//   text_i/cmd_i/cmd_w_i : registered word, command and strobe to the core
//   text_o               : hash word from core, valid one cycle after READ
//   cmd_o                : core status, cmd_o[BUSY_BIT] = busy
//   digest/digest_valid/digest_ready : 256-bit digest {H0..H7} handshake
//   err_timeout          : sticky flag, core busy never rose or never fell
module sha256_host_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC   = 256,
  parameter int unsigned WORDS_PER_BLK = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_first,
  input  logic         s_last,
  output logic [31:0]  text_i,
  output logic [2:0]   cmd_i,
  output logic         cmd_w_i,
  input  logic [31:0]  text_o,
  input  logic [3:0]   cmd_o,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic         err_timeout
);

  localparam int unsigned WCW = $clog2(WORDS_PER_BLK + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RCW = $clog2(HASH_WORDS);

  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS_PER_BLK - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT_CYC - 1);
  localparam logic [RCW-1:0] LAST_RD   = RCW'(HASH_WORDS - 1);

  ctrl_state_t    state;
  logic [WCW-1:0] wcnt;
  logic [RCW-1:0] rcnt;
  logic [TCW-1:0] tcnt;
  logic           first_q;
  logic           last_q;
  logic           busy;
  logic           blk_first;
  logic           unused_cmd_o;

  assign busy         = cmd_o[BUSY_BIT];
  assign unused_cmd_o = ^cmd_o;

  // Word 0 is accepted in IDLE, before first_q has been loaded, so the
  // first flag for the closing write comes straight from the input there.
  assign blk_first = (state == IDLE) ? s_first : first_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      s_ready      <= 1'b0;
      text_i       <= '0;
      cmd_i        <= '0;
      cmd_w_i      <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      err_timeout  <= 1'b0;
      wcnt         <= '0;
      rcnt         <= '0;
      tcnt         <= '0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      // Strobe is a single-cycle pulse unless a state re-asserts it.
      cmd_w_i <= 1'b0;

      unique case (state)
        // IDLE and LOAD share the accept path; IDLE additionally latches
        // the block position flags carried by word 0.
        IDLE, LOAD: begin
          if (s_valid && s_ready) begin
            text_i  <= s_data;
            cmd_w_i <= 1'b1;
            if (state == IDLE) begin
              first_q <= s_first;
              last_q  <= s_last;
            end
            if (wcnt == LAST_WORD) begin
              cmd_i   <= core_cmd(blk_first, CMD_WRITE);
              s_ready <= 1'b0;
              wcnt    <= '0;
              tcnt    <= '0;
              state   <= WAIT_RISE;
            end else begin
              cmd_i   <= core_cmd(1'b0, CMD_WRITE);
              wcnt    <= wcnt + 1'b1;
              s_ready <= 1'b1;
              state   <= LOAD;
            end
          end else if (state == IDLE) begin
            s_ready <= 1'b1;
          end
        end

        WAIT_RISE: begin
          if (busy) begin
            tcnt  <= '0;
            state <= WAIT_FALL;
          end else if (tcnt == TO_LAST) begin
            err_timeout <= 1'b1;
            state       <= ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        WAIT_FALL: begin
          if (!busy) begin
            tcnt <= '0;
            if (last_q) begin
              // Issue the first READ on the way in so the strobe is
              // visible during READ and its data during CAPT.
              cmd_w_i <= 1'b1;
              cmd_i   <= core_cmd(1'b0, CMD_READ);
              rcnt    <= '0;
              state   <= READ;
            end else begin
              s_ready <= 1'b1;
              state   <= IDLE;
            end
          end else if (tcnt == TO_LAST) begin
            err_timeout <= 1'b1;
            state       <= ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        READ: begin
          state <= CAPT;
        end

        CAPT: begin
          // Words arrive H0 first; shifting in from the bottom leaves H0
          // in [255:224] after the eighth capture.
          digest <= {digest[223:0], text_o};
          if (rcnt == LAST_RD) begin
            digest_valid <= 1'b1;
            state        <= OUT;
          end else begin
            rcnt    <= rcnt + 1'b1;
            cmd_w_i <= 1'b1;
            cmd_i   <= core_cmd(1'b0, CMD_READ);
            state   <= READ;
          end
        end

        OUT: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            s_ready      <= 1'b1;
            state        <= IDLE;
          end
        end

        ERR: begin
          s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Self-checking bench for sha256_host_ctrl with a behavioural SHA-256 core.
module tb_sha256_host_ctrl;

  localparam int unsigned TO     = 64;
  localparam int unsigned BUDGET = 2000;

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk = 1'b0;
  logic         reset;
  logic         s_valid, s_ready, s_first, s_last;
  logic [31:0]  s_data, text_i, text_o;
  logic [2:0]   cmd_i;
  logic         cmd_w_i;
  logic [3:0]   cmd_o;
  logic [255:0] digest;
  logic         digest_valid, digest_ready, err_timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sha256_host_ctrl #(.TIMEOUT_CYC(TO), .WORDS_PER_BLK(16)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_first(s_first), .s_last(s_last),
    .text_i(text_i), .cmd_i(cmd_i), .cmd_w_i(cmd_w_i), .text_o(text_o), .cmd_o(cmd_o),
    .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
    .err_timeout(err_timeout)
  );

  // ---------------- SHA-256 reference ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    a = h[255:224]; b = h[223:192]; c = h[191:160]; d = h[159:128];
    e = h[127:96];  f = h[95:64];   g = h[63:32];   hh = h[31:0];
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e,  h[95:64] + f,   h[63:32] + g,   h[31:0] + hh};
  endfunction

  // ---------------- behavioural core ----------------
  logic         no_busy   = 1'b0;
  int unsigned  rise_dly  = 2;
  int unsigned  busy_len  = 5;
  logic         core_busy;
  logic [511:0] wbuf, cblk;
  logic [255:0] cbase, h_core;
  int unsigned  widx, ridx, cnt;
  int unsigned  phase;

  assign cmd_o = {core_busy, 3'b000};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      widx      <= 0;
      ridx      <= 0;
      phase     <= 0;
      cnt       <= 0;
      core_busy <= 1'b0;
      h_core    <= IV;
      text_o    <= '0;
    end else begin
      if (cmd_w_i && cmd_i[1:0] == 2'b10) begin
        wbuf <= {wbuf[479:0], text_i};
        if (widx == 15) begin
          widx  <= 0;
          cblk  <= {wbuf[479:0], text_i};
          cbase <= cmd_i[2] ? IV : h_core;
          cnt   <= rise_dly;
          phase <= 1;
        end else begin
          widx <= widx + 1;
        end
      end else if (cmd_w_i && cmd_i[1:0] == 2'b01) begin
        text_o <= h_core[255 - 32*ridx -: 32];
        ridx   <= (ridx + 1) % 8;
      end
      case (phase)
        1: if (!no_busy) begin
             if (cnt == 0) begin core_busy <= 1'b1; cnt <= busy_len; phase <= 2; end
             else cnt <= cnt - 1;
           end
        2: if (cnt == 0) begin
             core_busy <= 1'b0;
             h_core    <= sha_compress(cbase, cblk);
             ridx      <= 0;
             phase     <= 0;
           end else cnt <= cnt - 1;
        default: ;
      endcase
    end
  end

  // ---------------- protocol monitor ----------------
  int unsigned wr_cnt = 0, rd_cnt = 0, first_cnt = 0;
  int unsigned bad_first = 0, bad_op = 0, bad_b2b = 0, bad_out = 0;
  int unsigned mpos = 0;
  logic        prev_w = 1'b0;

  always @(posedge clk) begin
    prev_w <= cmd_w_i;
    if (!reset) begin
      mpos <= 0;
    end else begin
      if (cmd_w_i) begin
        if (cmd_i[1:0] == 2'b10) begin
          wr_cnt <= wr_cnt + 1;
          if (cmd_i[2]) first_cnt <= first_cnt + 1;
          if (cmd_i[2] && mpos != 15) bad_first <= bad_first + 1;
          mpos <= (mpos == 15) ? 0 : mpos + 1;
        end else if (cmd_i == 3'b001) begin
          rd_cnt <= rd_cnt + 1;
          if (prev_w) bad_b2b <= bad_b2b + 1;
        end else begin
          bad_op <= bad_op + 1;
        end
      end
      if ((digest_valid && (s_ready || cmd_w_i)) || (err_timeout && cmd_w_i))
        bad_out <= bad_out + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_text_i"}, text_i, 0);
    chk({tag, "_cmd_i"}, cmd_i, 0);
    chk({tag, "_cmd_w_i"}, cmd_w_i, 0);
    chk({tag, "_digest"}, digest, 0);
    chk({tag, "_digest_valid"}, digest_valid, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_word(input logic [31:0] d, input logic f, input logic l);
    int unsigned n = 0;
    s_valid = 1'b1; s_data = d; s_first = f; s_last = l;
    while (s_ready !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
    if (n >= BUDGET) begin
      checks++; errors++;
      $error("FAIL s_ready_wait: observed=no ready in %0d cycles expected=ready", BUDGET);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic send_block(input logic [511:0] blk, input logic f, input logic l, input int unsigned maxgap);
    for (int i = 0; i < 16; i++) begin
      if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) @(negedge clk);
      if (i == 0) send_word(blk[511 -: 32], f, l);
      else send_word(blk[511 - 32*i -: 32], 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end
  endtask

  task automatic wait_digest(input logic [255:0] exp, input string tag, input int unsigned hold, input logic keep);
    int unsigned n = 0;
    int unsigned bad = 0;
    logic [255:0] d;
    while (digest_valid !== 1'b1 && n < BUDGET) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, digest_valid, 1);
    chk({tag, "_value"}, digest, exp);
    if (hold > 0) begin
      d = digest;
      repeat (hold) begin
        @(negedge clk);
        if (digest !== d || digest_valid !== 1'b1 || s_ready !== 1'b0) bad++;
      end
      chk({tag, "_hold"}, bad, 0);
    end
    digest_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_ready_next"}, s_ready, 1);
    chk({tag, "_valid_clr"}, digest_valid, 0);
    digest_ready = keep;
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b = '0;
    for (int i = 0; i < 16; i++) b = {b[479:0], 32'($urandom)};
    return b;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [255:0] exp_h;
    logic [511:0] blk;
    int unsigned  w0, r0, f0, nb;

    reset = 1'b0; s_valid = 1'b0; s_data = '0; s_first = 1'b0; s_last = 1'b0; digest_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;

    // Single-block "abc", consumer always ready.
    digest_ready = 1'b1;
    w0 = wr_cnt; r0 = rd_cnt; f0 = first_cnt;
    send_block(ABC_BLK, 1'b1, 1'b1, 0);
    wait_digest(ABC_DIG, "abc", 0, 1'b1);
    chk("abc_writes", wr_cnt - w0, 16);
    chk("abc_first_flags", first_cnt - f0, 1);
    chk("abc_reads", rd_cnt - r0, 8);

    // Two-block message, second block not first.
    w0 = wr_cnt; r0 = rd_cnt; f0 = first_cnt;
    send_block(TWO_B1, 1'b1, 1'b0, 0);
    send_block(TWO_B2, 1'b0, 1'b1, 0);
    wait_digest(TWO_DIG, "two", 0, 1'b0);
    chk("two_writes", wr_cnt - w0, 32);
    chk("two_first_flags", first_cnt - f0, 1);
    chk("two_reads", rd_cnt - r0, 8);

    // Random multi-block messages, gaps, consumer stalls 20 cycles.
    for (int m = 0; m < 3; m++) begin
      nb = $urandom_range(3, 1);
      rise_dly = $urandom_range(6, 1);
      busy_len = $urandom_range(30, 3);
      exp_h = IV;
      w0 = wr_cnt; r0 = rd_cnt; f0 = first_cnt;
      for (int b = 0; b < int'(nb); b++) begin
        blk = rand_block();
        exp_h = sha_compress(exp_h, blk);
        send_block(blk, b == 0, b == int'(nb) - 1, 3);
      end
      wait_digest(exp_h, "rand", 20, 1'b0);
      chk("rand_writes", wr_cnt - w0, 16 * nb);
      chk("rand_reads", rd_cnt - r0, 8);
      chk("rand_first_flags", first_cnt - f0, 1);
    end

    // Back-to-back messages: second starts right after the digest handshake.
    for (int m = 0; m < 2; m++) begin
      blk = rand_block();
      w0 = wr_cnt;
      send_block(blk, 1'b1, 1'b1, 0);
      wait_digest(sha_compress(IV, blk), "b2b", 0, 1'b0);
      chk("b2b_writes", wr_cnt - w0, 16);
    end

    // Reset in the middle of a block, then a clean "abc".
    w0 = wr_cnt;
    for (int i = 0; i < 8; i++) send_word(ABC_BLK[511 - 32*i -: 32], 1'b1, 1'b1);
    @(negedge clk);
    chk("midrst_writes", wr_cnt - w0, 8);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    reset = 1'b1;
    w0 = wr_cnt;
    send_block(ABC_BLK, 1'b1, 1'b1, 0);
    wait_digest(ABC_DIG, "after_rst", 0, 1'b0);
    chk("after_rst_writes", wr_cnt - w0, 16);

    // Core never raises busy: timeout after exactly TO cycles in WAIT_RISE.
    no_busy = 1'b1;
    send_block(ABC_BLK, 1'b1, 1'b1, 0);
    repeat (TO - 1) @(negedge clk);
    chk("to_before", err_timeout, 0);
    @(negedge clk);
    chk("to_at", err_timeout, 1);
    w0 = wr_cnt; r0 = rd_cnt;
    repeat (20) @(negedge clk);
    chk("to_no_strobes", (wr_cnt - w0) + (rd_cnt - r0), 0);
    chk("to_s_ready", s_ready, 0);
    chk("to_sticky", err_timeout, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("to_rst_clear", err_timeout, 0);
    no_busy = 1'b0;
    reset = 1'b1;

    chk("proto_first_pos", bad_first, 0);
    chk("proto_op", bad_op, 0);
    chk("proto_read_b2b", bad_b2b, 0);
    chk("proto_out_err", bad_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
